resp_collector: RTL and testbench

Parametrised in-order response collector ring of DEPTH entries for the PIM response path, with multicast "fake" bits preset by mask. Each incoming response goes to the first empty slot at or after the expected pointer, wrapping, so it never overwrites a preset fake bit. Entries retire in order from a head pointer. It replaces the fixed 8-entry combinational pointer search with a stateful, backpressured ring.

---
 rtl/resp_collector_pkg.sv | 32 +++
 rtl/resp_collector_if.sv | 37 +++
 rtl/resp_ptr_find.sv | 40 ++++
 rtl/resp_collector.sv | 124 ++++++++++++
 tb/tb_resp_collector.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/resp_collector_pkg.sv
// resp_coll_pkg: shared definitions for the response collector ring.
//   DEF_DEPTH / DEF_DATA_W : default ring depth and payload width
//   MAX_DEPTH              : largest supported ring; slot vectors are sized to it
//   coll_state_t           : per-slot occupancy and fake bits
//   popcount()             : number of set bits in a slot vector
package resp_coll_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_DATA_W = 128;
  localparam int MAX_DEPTH  = 64;
  localparam int IDX_W      = 6;
  localparam int POP_W      = 7;

  typedef logic [MAX_DEPTH-1:0] slot_vec_t;

  // Bits above DEPTH are never set, so the ring logic can work on full-width
  // vectors without special-casing the configured depth.
  typedef struct packed {
    slot_vec_t occ;
    slot_vec_t fake;
  } coll_state_t;

  function automatic logic [POP_W-1:0] popcount(input slot_vec_t v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/resp_collector_if.sv
// resp_collector_if: handshake bundle between the response collector and its
// neighbours.
//   fake_set_valid/mask : multicast fake-slot preset (bit i = slot i)
//   resp_valid/ready/data : incoming responses
//   out_valid/ready/data/fake : in-order head of the ring
//   occ_cnt, err_sticky : status
// Modport slave is the collector's view, master is the surrounding logic's.
interface resp_collector_if #(
  parameter int DEPTH  = resp_coll_pkg::DEF_DEPTH,
  parameter int DATA_W = resp_coll_pkg::DEF_DATA_W
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              fake_set_valid;
  logic [DEPTH-1:0]  fake_set_mask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_fake;
  logic [CNT_W-1:0]  occ_cnt;
  logic              err_sticky;

  modport slave (
    input  fake_set_valid, fake_set_mask, resp_valid, resp_data, out_ready,
    output resp_ready, out_valid, out_data, out_fake, occ_cnt, err_sticky
  );

  modport master (
    output fake_set_valid, fake_set_mask, resp_valid, resp_data, out_ready,
    input  resp_ready, out_valid, out_data, out_fake, occ_cnt, err_sticky
  );

endinterface

// File: rtl/resp_ptr_find.sv
// resp_ptr_find: finds the first free slot at or after a start pointer,
// wrapping around the ring.
//   occ   : per-slot occupancy
//   start : search origin
//   ptr   : first free slot in ring order from start (meaningless when full)
//   full  : every slot occupied
module resp_ptr_find #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] occ,
  input  logic [PTR_W-1:0] start,
  output logic [PTR_W-1:0] ptr,
  output logic             full
);

  logic [DEPTH-1:0] rot;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] offs;

  // Rotate so that bit 0 of rot is the start slot, then take the lowest zero;
  // scanning downward leaves the nearest free slot as the final winner.
  always_comb begin
    rot  = '0;
    idx  = '0;
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx    = start + PTR_W'(i);
      rot[i] = occ[idx];
    end
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!rot[k]) begin
        offs = PTR_W'(k);
      end
    end
    ptr  = start + offs;
    full = &occ;
  end

endmodule

// File: rtl/resp_collector.sv
// resp_collector: in-order response collector ring with multicast fake slots.
// Responses fill the first empty slot at or after the expected pointer, so
// preset fake slots are skipped; entries retire in order from the head.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : resp_collector_if.slave (push, fake preset, head, status)
// Build option RESP_COLL_FAKE_DROP_EN: fake head entries retire internally,
// one per cycle, and only real entries are shown downstream (out_fake = 0).
// Without it, fake entries are presented with out_fake = 1 and wait for
// out_ready like any other entry.
module resp_collector
  import resp_coll_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic             clk,
  input logic             rst_n,
  resp_collector_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  coll_state_t       state_q;
  coll_state_t       state_d;
  logic [PTR_W-1:0]  exp_ptr;
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  push_ptr;
  logic [CNT_W-1:0]  occ_cnt_q;
  logic              err_q;
  logic              full;
  logic              push;
  logic              pop;
  logic              head_occ;
  logic              head_fake;
  logic              collide;
  slot_vec_t         push_oh;
  slot_vec_t         pop_oh;
  slot_vec_t         mask_ext;
  slot_vec_t         fake_new;
  logic [POP_W-1:0]  fake_cnt;
  logic [DATA_W-1:0] data_q [DEPTH];

  resp_ptr_find #(.DEPTH(DEPTH)) u_find (
    .occ   (state_q.occ[DEPTH-1:0]),
    .start (exp_ptr),
    .ptr   (push_ptr),
    .full  (full)
  );

  assign head_occ  = state_q.occ[IDX_W'(head_ptr)];
  assign head_fake = state_q.fake[IDX_W'(head_ptr)];
  assign push      = bus.resp_valid & ~full;

`ifdef RESP_COLL_FAKE_DROP_EN
  assign pop           = head_occ & (head_fake | bus.out_ready);
  assign bus.out_valid = head_occ & ~head_fake;
  assign bus.out_fake  = 1'b0;
`else
  assign pop           = head_occ & bus.out_ready;
  assign bus.out_valid = head_occ;
  assign bus.out_fake  = head_occ & head_fake;
`endif

  assign bus.resp_ready = ~full;
  assign bus.out_data   = data_q[head_ptr];
  assign bus.occ_cnt    = occ_cnt_q;
  assign bus.err_sticky = err_q;

  // Next-state slot vectors. The pop clears first and new writes are OR'd in
  // afterwards. A fake bit landing on an occupied slot or on this cycle's
  // push target is dropped and flagged as a collision.
  always_comb begin
    push_oh      = '0;
    pop_oh       = '0;
    mask_ext     = '0;
    if (push) begin
      push_oh = slot_vec_t'(1) << push_ptr;
    end
    if (pop) begin
      pop_oh = slot_vec_t'(1) << head_ptr;
    end
    if (bus.fake_set_valid) begin
      mask_ext = slot_vec_t'(bus.fake_set_mask);
    end
    fake_new     = mask_ext & ~state_q.occ & ~push_oh;
    collide      = |(mask_ext & (state_q.occ | push_oh));
    state_d.occ  = (state_q.occ & ~pop_oh) | push_oh | fake_new;
    state_d.fake = (state_q.fake & ~pop_oh & ~push_oh) | fake_new;
    fake_cnt     = popcount(fake_new);
  end

  // Control state. occ_cnt is tracked incrementally rather than recounted so
  // it stays registered alongside occ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= '0;
      exp_ptr   <= '0;
      head_ptr  <= '0;
      occ_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_cnt_q <= occ_cnt_q + CNT_W'(push) + CNT_W'(fake_cnt) - CNT_W'(pop);
      if (push) begin
        exp_ptr <= push_ptr + 1'b1;
      end
      if (pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      if (collide) begin
        err_q <= 1'b1;
      end
    end
  end

  // Payload storage is not reset; a slot's data is only read once occ is set.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[push_ptr] <= bus.resp_data;
    end
  end

endmodule

// File: tb/tb_resp_collector.sv
// tb_resp_collector: randomized and directed stimulus for resp_collector,
// compared every cycle against a slot-array reference model.
// Honours RESP_COLL_FAKE_DROP_EN the same way the design does.
module tb_resp_collector;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 128;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  resp_collector_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  resp_collector #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what each slot holds, plus the two ring pointers.
  bit              m_occ  [DEPTH];
  bit              m_fake [DEPTH];
  logic [DATA_W-1:0] m_data [DEPTH];
  int              m_exp;
  int              m_head;
  bit              m_err;

  function automatic int modelCount();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_occ[i]);
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] rndData();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      m_occ[i]  = 1'b0;
      m_fake[i] = 1'b0;
    end
    m_exp  = 0;
    m_head = 0;
    m_err  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Compare every observable output with what the model says it should be.
  task automatic checkAll();
    bit exp_valid;
    bit exp_fake;
`ifdef RESP_COLL_FAKE_DROP_EN
    exp_valid = m_occ[m_head] && !m_fake[m_head];
    exp_fake  = 1'b0;
`else
    exp_valid = m_occ[m_head];
    exp_fake  = m_occ[m_head] && m_fake[m_head];
`endif
    checkOutput("out_valid", DATA_W'(bus.out_valid), DATA_W'(exp_valid));
    checkOutput("out_fake", DATA_W'(bus.out_fake), DATA_W'(exp_fake));
    checkOutput("resp_ready", DATA_W'(bus.resp_ready), DATA_W'(modelCount() < DEPTH));
    checkOutput("occ_cnt", DATA_W'(bus.occ_cnt), DATA_W'(modelCount()));
    checkOutput("err_sticky", DATA_W'(bus.err_sticky), DATA_W'(m_err));
    if (exp_valid && !m_fake[m_head]) begin
      checkOutput("out_data", bus.out_data, m_data[m_head]);
    end
  endtask

  // One cycle: check the current state, drive inputs, advance the model,
  // then step to the next falling edge.
  task automatic applyStimulus(input bit fsv, input logic [DEPTH-1:0] mask,
                               input bit rv, input logic [DATA_W-1:0] d,
                               input bit ordy);
    bit push_f;
    bit pop_f;
    int pp;
    bit set_f [DEPTH];
    checkAll();
    bus.fake_set_valid = fsv;
    bus.fake_set_mask  = mask;
    bus.resp_valid     = rv;
    bus.resp_data      = d;
    bus.out_ready      = ordy;

    push_f = rv && (modelCount() < DEPTH);
    pp = 0;
    if (push_f) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (!m_occ[(m_exp + k) % DEPTH]) pp = (m_exp + k) % DEPTH;
      end
    end
`ifdef RESP_COLL_FAKE_DROP_EN
    pop_f = m_occ[m_head] && (m_fake[m_head] || ordy);
`else
    pop_f = m_occ[m_head] && ordy;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      set_f[i] = 1'b0;
      if (fsv && mask[i]) begin
        if (m_occ[i] || (push_f && i == pp)) m_err = 1'b1;
        else set_f[i] = 1'b1;
      end
    end
    if (pop_f) begin
      m_occ[m_head]  = 1'b0;
      m_fake[m_head] = 1'b0;
      m_head = (m_head + 1) % DEPTH;
    end
    if (push_f) begin
      m_occ[pp]  = 1'b1;
      m_fake[pp] = 1'b0;
      m_data[pp] = d;
      m_exp = (pp + 1) % DEPTH;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (set_f[i]) begin
        m_occ[i]  = 1'b1;
        m_fake[i] = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset taken between clock edges; outputs are checked while
  // reset is still low and before any further clock edge.
  task automatic doReset();
    bus.fake_set_valid = 1'b0;
    bus.fake_set_mask  = '0;
    bus.resp_valid     = 1'b0;
    bus.out_ready      = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, ordy);
  endtask

  initial begin
    rst_n              = 1'b1;
    bus.fake_set_valid = 1'b0;
    bus.fake_set_mask  = '0;
    bus.resp_valid     = 1'b0;
    bus.resp_data      = '0;
    bus.out_ready      = 1'b0;
    modelReset();
    doReset();

    // Three pushes fill slots 0..2, then drain in order.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, rndData(), 1'b0);
    idle(4, 1'b1);

    // Fake preset on slots 1,2 after A; D must skip to slot 3.
    doReset();
    applyStimulus(1'b0, '0, 1'b1, rndData(), 1'b0);
    applyStimulus(1'b1, 8'b0000_0110, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, rndData(), 1'b0);
    idle(6, 1'b1);

    // Fill the ring, hold a push while full, free one slot, push with wrap.
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, rndData(), 1'b0);
    applyStimulus(1'b0, '0, 1'b1, rndData(), 1'b0);
    applyStimulus(1'b0, '0, 1'b1, rndData(), 1'b0);
    applyStimulus(1'b0, '0, 1'b1, rndData(), 1'b1);
    applyStimulus(1'b0, '0, 1'b1, rndData(), 1'b0);
    idle(DEPTH + 2, 1'b1);

    // Fake bits on occupied slot 0 and on the push target slot 5.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, rndData(), 1'b0);
    applyStimulus(1'b1, 8'b0010_0001, 1'b1, rndData(), 1'b0);
    idle(3, 1'b0);
    idle(8, 1'b1);

    // Mid-stream asynchronous reset with five entries held, then restart.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, rndData(), 1'b0);
    doReset();
    applyStimulus(1'b0, '0, 1'b1, rndData(), 1'b0);
    idle(2, 1'b1);

    // Random traffic with occasional fake presets and periodic resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) doReset();
      applyStimulus(($urandom_range(0, 7) == 0), DEPTH'($urandom),
                    ($urandom_range(0, 3) != 0), rndData(),
                    ($urandom_range(0, 2) != 0));
    end
    checkAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
